// File: rtl/asic_sprite_linebuf_if.sv
// asic_sprite_linebuf_if: CPU register bus and video pixel stream of the sprite line buffer
interface asic_sprite_linebuf_if #(
   parameter int NUM_SPRITES = 16,
   parameter int XW = 10,
   parameter int YW = 9
);
   logic cpu_wr;
   logic [13:0] cpu_addr;
   logic [7:0] cpu_data;
   logic coll_clr;
   logic line_start;
   logic [YW-1:0] next_line;
   logic [XW-1:0] hpos;
   logic pix_valid;
   logic [3:0] sprite_pixel;
   logic sprite_active;
   logic [3:0] sprite_id;
   logic [NUM_SPRITES-1:0] collision_flags;
   logic busy;
   logic overrun;
   modport master(
      output cpu_wr, cpu_addr, cpu_data, coll_clr, line_start, next_line, hpos, pix_valid,
      input sprite_pixel, sprite_active, sprite_id, collision_flags, busy, overrun
   );
   modport slave(
      input cpu_wr, cpu_addr, cpu_data, coll_clr, line_start, next_line, hpos, pix_valid,
      output sprite_pixel, sprite_active, sprite_id, collision_flags, busy, overrun
   );
endinterface

// File: rtl/asic_sprite_linebuf.sv
// asic_sprite_linebuf: Plus-mode sprite engine rendering the next line into a double-buffered line buffer
module asic_sprite_linebuf #(
   parameter int NUM_SPRITES = 16,
   parameter int XW = 10,
   parameter int YW = 9
) (
   input logic clk_sys,
   input logic reset_n,
   input logic enable,
   asic_sprite_linebuf_if.slave bus
);
   localparam int SW = $clog2(NUM_SPRITES);
   localparam int D = 2**XW;
   typedef enum logic [1:0] {IDLE, SCAN, FETCH} state_t;
   state_t state, state_n;
   logic [3:0] pat [NUM_SPRITES*256];
   logic [XW-1:0] x_r [NUM_SPRITES];
   logic [YW-1:0] y_r [NUM_SPRITES];
   logic [3:0] mag [NUM_SPRITES];
   logic [D-1:0] vld [2];
   logic [7:0] ent [2][D];
   logic wb, ovr;
   logic [SW-1:0] s;
   logic [5:0] c;
   logic [3:0] row, pix_q, id_q, pen, occ_id;
   logic [XW-1:0] cur_x;
   logic [1:0] cur_xm, xm, ym;
   logic [YW-1:0] ln, d;
   logic [NUM_SPRITES-1:0] coll, coll_set;
   logic [6:0] lim_y, lim_x;
   logic [XW:0] tx;
   logic pat_we, att_we, ls, scan, fetch, hit, last_s, last_c, in_rng, occ, do_wr, rd;
   assign pat_we = bus.cpu_wr && bus.cpu_addr[13:12] == 2'b00 && {1'b0, bus.cpu_addr[11:8]} < 5'(NUM_SPRITES);
   assign att_we = bus.cpu_wr && bus.cpu_addr[13:7] == 7'b1000000 && {1'b0, bus.cpu_addr[6:3]} < 5'(NUM_SPRITES);
   assign ls = enable && bus.line_start;
   assign scan = enable && !bus.line_start && state == SCAN;
   assign fetch = enable && !bus.line_start && state == FETCH;
   assign rd = enable && bus.pix_valid;
   assign xm = mag[s][1:0];
   assign ym = mag[s][3:2];
   assign d = ln - y_r[s];
   assign lim_y = 7'd16 << (ym - 2'd1);
   assign hit = xm != 2'd0 && ym != 2'd0 && d < YW'(lim_y);
   assign last_s = s == SW'(NUM_SPRITES - 1);
   assign lim_x = 7'd16 << (cur_xm - 2'd1);
   assign last_c = {1'b0, c} == lim_x - 7'd1;
   assign tx = {1'b0, cur_x} + (XW+1)'(c);
   assign in_rng = !tx[XW];
   assign pen = pat[{s, row, 4'(c >> (cur_xm - 2'd1))}];
   assign occ = vld[wb][tx[XW-1:0]];
   assign occ_id = ent[wb][tx[XW-1:0]][7:4];
   assign do_wr = fetch && in_rng && pen != 4'h0 && !occ;
   // an occupied target means a lower-indexed sprite already owns the pixel
   assign coll_set = (fetch && in_rng && pen != 4'h0 && occ) ?
                     (NUM_SPRITES'(1) << s) | (NUM_SPRITES'(1) << occ_id[SW-1:0]) : '0;
   always_comb begin
      state_n = state;
      if (!enable) state_n = IDLE;
      else if (bus.line_start) state_n = SCAN;
      else if (state == SCAN) state_n = hit ? FETCH : (last_s ? IDLE : SCAN);
      else if (state == FETCH && last_c) state_n = last_s ? IDLE : SCAN;
   end
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wb <= 1'b0;
         s <= '0;
         c <= '0;
         row <= '0;
         cur_x <= '0;
         cur_xm <= '0;
         ln <= '0;
         ovr <= 1'b0;
         coll <= '0;
      end else begin
         if (ls) begin
            wb <= ~wb;
            s <= '0;
            ln <= bus.next_line;
         end
         if (scan && hit) begin
            c <= '0;
            row <= 4'(d >> (ym - 2'd1));
            cur_x <= x_r[s];
            cur_xm <= xm;
         end
         if (scan && !hit) s <= s + 1'b1;
         if (fetch) c <= c + 1'b1;
         if (fetch && last_c) s <= s + 1'b1;
         ovr <= (ls && state != IDLE) || (ovr && !bus.coll_clr);
         coll <= (bus.coll_clr ? '0 : coll) | coll_set;
      end
   end
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_r[i] <= '0;
            y_r[i] <= '0;
            mag[i] <= '0;
         end
      end else if (att_we) begin
         case (bus.cpu_addr[2:0])
            3'd0: x_r[bus.cpu_addr[3 +: SW]][7:0] <= bus.cpu_data;
            3'd1: x_r[bus.cpu_addr[3 +: SW]][XW-1:8] <= bus.cpu_data[XW-9:0];
            3'd2: y_r[bus.cpu_addr[3 +: SW]][7:0] <= bus.cpu_data;
            3'd3: y_r[bus.cpu_addr[3 +: SW]][YW-1:8] <= bus.cpu_data[YW-9:0];
            3'd4: mag[bus.cpu_addr[3 +: SW]] <= bus.cpu_data[3:0];
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk_sys)
      if (pat_we) pat[{bus.cpu_addr[8 +: SW], bus.cpu_addr[7:0]}] <= bus.cpu_data[3:0];
   always_ff @(posedge clk_sys)
      if (do_wr) ent[wb][tx[XW-1:0]] <= {4'(s), pen};
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         vld[0] <= '0;
         vld[1] <= '0;
      end else begin
         if (do_wr) vld[wb][tx[XW-1:0]] <= 1'b1;
         if (rd) vld[~wb][bus.hpos] <= 1'b0;
      end
   end
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) {id_q, pix_q} <= '0;
      else {id_q, pix_q} <= (rd && vld[~wb][bus.hpos]) ? ent[~wb][bus.hpos] : 8'h00;
   assign bus.sprite_pixel = enable ? pix_q : 4'h0;
   assign bus.sprite_active = bus.sprite_pixel != 4'h0;
   assign bus.sprite_id = enable ? id_q : 4'h0;
   assign bus.collision_flags = enable ? coll : '0;
   assign bus.busy = enable && state != IDLE;
   assign bus.overrun = enable && ovr;
endmodule
